bcd_freq_counter: RTL and testbench

Measurement stage of the digital frequency meter, directly downstream of the gate-timing controller. It counts rising edges of the unknown input `sig_in` while the controller's `count_en` gate is high. It snapshots the count into an output register on `latch_en` and zeroes the counter on `clear`. The latched BCD value goes to the display/decoder stage, so with a 1 s gate the reading is the input frequency in Hz.

---
 rtl/freq_meter_pkg.sv | 21 ++
 rtl/bcd_digit.sv | 44 ++++
 rtl/bcd_freq_counter.sv | 173 +++++++++++++++++
 tb/tb_bcd_freq_counter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency-meter measurement stage.
package freq_meter_pkg;

   // Largest legal value of a single BCD decade.
   localparam logic [3:0] BCD_MAX = 4'd9;

   // Default build: eight decades, two-flop synchronizers.
   localparam int unsigned DEF_DIGITS      = 8;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   typedef logic [3:0] bcd_digit_t;

   // Bundle of the asynchronous controller/measurement inputs, synchronized together.
   typedef struct packed {
      logic clear;
      logic latch;
      logic en;
      logic sig;
   } ctrl_in_t;

endpackage : freq_meter_pkg

// File: rtl/bcd_digit.sv
// One BCD decade: clears, increments, wraps 9 -> 0.
// `carry` is the terminal-count level (digit at 9 or an illegal code), independent
// of `inc`, so the parent can build the ripple and the saturation test without a loop.
module bcd_digit
   import freq_meter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output bcd_digit_t q,
   output logic       carry
);

   bcd_digit_t q_q;
   bcd_digit_t q_d;

   // Next digit value: clear wins, otherwise increment with wrap; codes 10-15 wrap like 9.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc) begin
         if (q_q >= BCD_MAX) begin
            q_d = '0;
         end else begin
            q_d = q_q + 4'd1;
         end
      end
   end

   // Digit register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign carry = (q_q >= BCD_MAX);

endmodule : bcd_digit

// File: rtl/bcd_freq_counter.sv
// Measurement stage of the frequency meter: counts synchronized rising edges of
// sig_in while the count_en gate is high, snapshots on latch_en, zeroes on clear.
module bcd_freq_counter
   import freq_meter_pkg::*;
#(
   parameter int unsigned DIGITS      = DEF_DIGITS,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sig_in,
   input  logic                  count_en,
   input  logic                  latch_en,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   freq_bcd,
   output logic                  overflow,
   output logic                  valid
);

   // ---------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------
   ctrl_in_t                    in_raw;
   ctrl_in_t [SYNC_STAGES-1:0]  sync_q;
   ctrl_in_t [SYNC_STAGES-1:0]  sync_d;
   ctrl_in_t                    in_sync;

   logic sig_prev_q,   sig_prev_d;
   logic latch_prev_q, latch_prev_d;
   logic clear_prev_q, clear_prev_d;

   logic sig_rise;
   logic latch_pulse;
   logic clear_pulse;
   logic en_sync;

   assign in_raw.clear = clear;
   assign in_raw.latch = latch_en;
   assign in_raw.en    = count_en;
   assign in_raw.sig   = sig_in;

   // Shift every input one stage deeper into its own synchronizer chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], in_raw};
   end

   // Synchronizer flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign in_sync = sync_q[SYNC_STAGES-1];
   assign en_sync = in_sync.en;

   // Previous synchronized values for edge detection.
   always_comb begin
      sig_prev_d   = in_sync.sig;
      latch_prev_d = in_sync.latch;
      clear_prev_d = in_sync.clear;
   end

   // Edge-detect flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_prev_q   <= 1'b0;
         latch_prev_q <= 1'b0;
         clear_prev_q <= 1'b0;
      end else begin
         sig_prev_q   <= sig_prev_d;
         latch_prev_q <= latch_prev_d;
         clear_prev_q <= clear_prev_d;
      end
   end

   assign sig_rise    = in_sync.sig   & ~sig_prev_q;
   assign latch_pulse = in_sync.latch & ~latch_prev_q;
   assign clear_pulse = in_sync.clear & ~clear_prev_q;

   // ---------------------------------------------------------------------------
   // BCD counter
   // ---------------------------------------------------------------------------
   logic [4*DIGITS-1:0] cnt;
   logic [DIGITS-1:0]   carry;
   logic [DIGITS-1:0]   digit_inc;
   logic                inc_req;
   logic                sat;
   logic                ovf_cnt_q, ovf_cnt_d;

   assign inc_req = sig_rise & en_sync;
   assign sat     = &carry;

   // Ripple the increment through the decades; at all-9s nothing moves (saturate).
   always_comb begin
      digit_inc    = '0;
      digit_inc[0] = inc_req & ~sat;
      for (int unsigned i = 1; i < DIGITS; i++) begin
         digit_inc[i] = digit_inc[i-1] & carry[i-1];
      end
   end

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_digit
         bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .inc   (digit_inc[g]),
            .clr   (clear_pulse),
            .q     (cnt[4*g +: 4]),
            .carry (carry[g])
         );
      end
   endgenerate

   // Sticky overflow: cleared by clear, set by an increment attempted at full scale.
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (clear_pulse) begin
         ovf_cnt_d = 1'b0;
      end else if (inc_req && sat) begin
         ovf_cnt_d = 1'b1;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_cnt_q <= 1'b0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Output latch
   // ---------------------------------------------------------------------------
   logic [4*DIGITS-1:0] freq_q, freq_d;
   logic                overflow_q, overflow_d;
   logic                valid_q, valid_d;

   // Snapshot the pre-update count so same-cycle clear/increment is not captured.
   always_comb begin
      freq_d     = freq_q;
      overflow_d = overflow_q;
      valid_d    = latch_pulse;
      if (latch_pulse) begin
         freq_d     = cnt;
         overflow_d = ovf_cnt_q;
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         freq_q     <= '0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         freq_q     <= freq_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
      end
   end

   assign freq_bcd = freq_q;
   assign overflow = overflow_q;
   assign valid    = valid_q;

endmodule : bcd_freq_counter

// File: tb/tb_bcd_freq_counter.sv
// Scoreboard bench: two instances (8 decades / 2 decades) share one stimulus
// stream; expected latch results come from an integer edge-count model.
module tb_bcd_freq_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        sig_in;
   logic        count_en;
   logic        latch_en;
   logic        clear;
   logic [31:0] freq8;
   logic        ovf8, valid8;
   logic [7:0]  freq2;
   logic        ovf2, valid2;

   bcd_freq_counter #(.DIGITS(8), .SYNC_STAGES(2)) dut8 (
      .clk(clk), .rst(rst), .sig_in(sig_in), .count_en(count_en),
      .latch_en(latch_en), .clear(clear),
      .freq_bcd(freq8), .overflow(ovf8), .valid(valid8)
   );

   bcd_freq_counter #(.DIGITS(2), .SYNC_STAGES(3)) dut2 (
      .clk(clk), .rst(rst), .sig_in(sig_in), .count_en(count_en),
      .latch_en(latch_en), .clear(clear),
      .freq_bcd(freq2), .overflow(ovf2), .valid(valid2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] bcd;
      logic        ovf;
   } exp_t;

   exp_t        q8[$];
   exp_t        q2[$];
   int          tests = 0;
   int          fails = 0;
   int unsigned n     = 0;   // gated edges since last clear/reset

   // Reference: saturate the edge count at 10^digits-1 and express it in BCD.
   function automatic exp_t model(int unsigned edges, int unsigned digits);
      exp_t            r;
      longint unsigned fs = 1;
      longint unsigned v;
      for (int unsigned d = 0; d < digits; d++) fs = fs * 10;
      fs    = fs - 1;
      v     = (edges > fs) ? fs : longint'(edges);
      r.ovf = (edges > fs);
      r.bcd = '0;
      for (int unsigned i = 0; i < digits; i++) begin
         r.bcd[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding latch request.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0) begin
         if (valid8 === 1'b1) begin
            if (q8.size() == 0) check("dut8 unexpected valid", 32'(valid8), 32'd0);
            else begin
               e = q8.pop_front();
               check("dut8 freq_bcd", freq8, e.bcd);
               check("dut8 overflow", 32'(ovf8), 32'(e.ovf));
            end
         end
         if (valid2 === 1'b1) begin
            if (q2.size() == 0) check("dut2 unexpected valid", 32'(valid2), 32'd0);
            else begin
               e = q2.pop_front();
               check("dut2 freq_bcd", {24'd0, freq2}, e.bcd);
               check("dut2 overflow", 32'(ovf2), 32'(e.ovf));
            end
         end
      end
   end

   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #2;
   endtask

   task automatic edges(input int k, input bit fixed);
      for (int i = 0; i < k; i++) begin
         sig_in = 1'b1;
         if (count_en) n++;
         cyc(fixed ? 4 : 2 + int'($urandom_range(0, 2)));
         sig_in = 1'b0;
         cyc(fixed ? 4 : 2 + int'($urandom_range(0, 2)));
      end
   endtask

   task automatic gate(input bit v);
      count_en = v;
      cyc(8);
   endtask

   task automatic do_latch(input bit with_clear);
      q8.push_back(model(n, 8));
      q2.push_back(model(n, 2));
      latch_en = 1'b1;
      if (with_clear) begin
         clear = 1'b1;
         n     = 0;
      end
      cyc(10);
      latch_en = 1'b0;
      clear    = 1'b0;
      cyc(10);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      n     = 0;
      cyc(10);
      clear = 1'b0;
      cyc(10);
   endtask

   initial begin
      rst = 1'b1; sig_in = 1'b0; count_en = 1'b0; latch_en = 1'b0; clear = 1'b0;
      cyc(4);
      check("reset dut8 freq_bcd", freq8, 32'd0);
      check("reset dut8 overflow", 32'(ovf8), 32'd0);
      check("reset dut8 valid", 32'(valid8), 32'd0);
      check("reset dut2 freq_bcd", {24'd0, freq2}, 32'd0);
      rst = 1'b0;
      cyc(5);

      // Nominal 1000-edge window at 80 ns period.
      gate(1'b1); edges(1000, 1'b1); gate(1'b0); do_latch(1'b0);

      // Carry chain 999 -> 1000.
      do_clear(); gate(1'b1); edges(999, 1'b0); do_latch(1'b0);
      edges(1, 1'b0); do_latch(1'b0); gate(1'b0);

      // Saturation of the 2-decade instance, then clear.
      do_clear(); gate(1'b1); edges(150, 1'b0); gate(1'b0); do_latch(1'b0);
      do_clear(); do_latch(1'b0);

      // Edges with the gate closed are ignored.
      edges(50, 1'b0); do_latch(1'b0);

      // Simultaneous latch and clear, then confirm the counter restarted at 0.
      gate(1'b1); edges(42, 1'b0); gate(1'b0); do_latch(1'b1); do_latch(1'b0);

      // Random windows, gate-off noise, optional clears and combined latch/clear.
      repeat (6) begin
         if ($urandom_range(0, 1) == 1) do_clear();
         gate(1'b1); edges(int'($urandom_range(0, 130)), 1'b0);
         gate(1'b0); edges(int'($urandom_range(0, 10)), 1'b0);
         do_latch(bit'($urandom_range(0, 1)));
      end

      // Reset in the middle of a gate window.
      do_clear(); gate(1'b1); edges(300, 1'b0); do_latch(1'b0); edges(20, 1'b0);
      #1;
      rst = 1'b1; sig_in = 1'b0; count_en = 1'b0; latch_en = 1'b0; clear = 1'b0;
      n = 0;
      #1;
      check("midreset dut8 freq_bcd", freq8, 32'd0);
      check("midreset dut8 overflow", 32'(ovf8), 32'd0);
      check("midreset dut8 valid", 32'(valid8), 32'd0);
      check("midreset dut2 freq_bcd", {24'd0, freq2}, 32'd0);
      check("midreset dut2 overflow", 32'(ovf2), 32'd0);
      cyc(3);
      rst = 1'b0;
      cyc(5);
      gate(1'b1); edges(1000, 1'b0); gate(1'b0); do_latch(1'b0);

      cyc(20);
      check("dut8 latches without valid", q8.size(), 32'd0);
      check("dut2 latches without valid", q2.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_bcd_freq_counter
